// File: rtl/l1d_upstream_arb.sv
// l1d_upstream_arb: NUM_CH-channel front end for the L1D core.
//   Round-robin arbitration of per-channel tag requests onto the single
//   upstream port, routing of tag-hit / cancel / ack back to the owning
//   channel, and a per-channel outstanding-credit limit.
//
// Optional feature macro: L1D_UPARB_QOS_EN
//   defined   : adds ch_prio_i; high-priority eligible channels always win,
//               with a separate RR pointer per class.
//   undefined : single-class round robin.
//
// Ports
//   clk, rst_n          core clock, async active-low reset
//   ch_req_vld_i/rdy_o  per-channel request handshake
//   ch_req_pld_i        per-channel payload, channel i at [i*PLD_W +: PLD_W]
//   ch_cancel_i         cancel last accepted transaction of channel i
//   ch_prio_i           (QoS build only) per-channel high-priority class
//   ch_tag_hit_o        tag hit routed to the channel accepted last cycle
//   ch_ack_en_o         ack strobe routed by core_ack_ch_i
//   ch_ack_dat_o        ack data broadcast to all channels
//   ch_credit_full_o    channel i has OST_MAX requests outstanding
//   core_req_*          upstream request port into the L1D core
//   core_cancel_o       cancel_last_trans into the L1D core
//   core_tag_hit_i      upstream tag hit from the L1D core
//   core_ack_*_i        upstream ack from the L1D core
//   err_underflow_o     sticky: ack/cancel for a channel with 0 outstanding
module l1d_upstream_arb #(
  parameter int unsigned  NUM_CH  = 4,
  parameter int unsigned  PLD_W   = 64,
  parameter int unsigned  DATA_W  = 64,
  parameter int unsigned  OST_MAX = 4,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_req_vld_i,
  output logic [NUM_CH-1:0]       ch_req_rdy_o,
  input  logic [NUM_CH*PLD_W-1:0] ch_req_pld_i,
  input  logic [NUM_CH-1:0]       ch_cancel_i,
`ifdef L1D_UPARB_QOS_EN
  input  logic [NUM_CH-1:0]       ch_prio_i,
`endif
  output logic [NUM_CH-1:0]       ch_tag_hit_o,
  output logic [NUM_CH-1:0]       ch_ack_en_o,
  output logic [DATA_W-1:0]       ch_ack_dat_o,
  output logic [NUM_CH-1:0]       ch_credit_full_o,
  output logic                    core_req_vld_o,
  input  logic                    core_req_rdy_i,
  output logic [PLD_W-1:0]        core_req_pld_o,
  output logic [CH_W-1:0]         core_req_ch_o,
  output logic                    core_cancel_o,
  input  logic                    core_tag_hit_i,
  input  logic                    core_ack_en_i,
  input  logic [CH_W-1:0]         core_ack_ch_i,
  input  logic [DATA_W-1:0]       core_ack_dat_i,
  output logic                    err_underflow_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_X = CNT_W + 1;

  // First set bit of mask at or after ptr, wrapping; returns {found, id}.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W-1:0]   ptr);
    logic              found;
    logic [CH_W-1:0]   id;
    logic [CH_W-1:0]   sel;
    int unsigned       idx;
    found = 1'b0;
    id    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = CH_W'(idx);
      if (!found && mask[sel]) begin
        found = 1'b1;
        id    = sel;
      end
    end
    return {found, id};
  endfunction

  function automatic logic [CH_W-1:0] ptr_after(input logic [CH_W-1:0] id);
    return (id == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(id + 1'b1);
  endfunction

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            full_q, full_d;
  logic [CH_W-1:0]              last_ch_q, last_ch_d;
  logic                         last_vld_q, last_vld_d;
  logic                         err_q, err_d;
`ifdef L1D_UPARB_QOS_EN
  logic [CH_W-1:0]              rr_hi_q, rr_hi_d;
  logic [CH_W-1:0]              rr_lo_q, rr_lo_d;
  logic [CH_W:0]                pick_hi, pick_lo;
  logic                         hi_sel;
`else
  logic [CH_W-1:0]              rr_q, rr_d;
  logic [CH_W:0]                pick;
`endif

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_id;
  logic              accept;
  logic              cancel_fwd;
  logic [NUM_CH-1:0] ack_hit;
  logic              inc_v;
  logic [CNT_X-1:0]  sum_v, dec_v;

  // Eligibility and grant selection.
  always_comb begin
    eligible  = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
`ifdef L1D_UPARB_QOS_EN
    hi_sel    = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = ch_req_vld_i[i] && (cnt_q[i] < CNT_W'(OST_MAX));
    end
`ifdef L1D_UPARB_QOS_EN
    pick_hi = rr_pick(eligible & ch_prio_i, rr_hi_q);
    pick_lo = rr_pick(eligible & ~ch_prio_i, rr_lo_q);
    if (pick_hi[CH_W]) begin
      hi_sel    = 1'b1;
      grant_vld = 1'b1;
      grant_id  = pick_hi[CH_W-1:0];
    end else begin
      grant_vld = pick_lo[CH_W];
      grant_id  = pick_lo[CH_W-1:0];
    end
`else
    pick      = rr_pick(eligible, rr_q);
    grant_vld = pick[CH_W];
    grant_id  = pick[CH_W-1:0];
`endif
  end

  // Upstream request mux and per-channel return routing.
  always_comb begin
    grant          = '0;
    ack_hit        = '0;
    ch_tag_hit_o   = '0;
    core_req_pld_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      grant[i]        = grant_vld && (grant_id == CH_W'(i));
      ack_hit[i]      = core_ack_en_i && (core_ack_ch_i == CH_W'(i));
      ch_tag_hit_o[i] = last_vld_q && core_tag_hit_i && (last_ch_q == CH_W'(i));
    end
    if (grant_vld) core_req_pld_o = ch_req_pld_i[32'(grant_id)*PLD_W +: PLD_W];
  end

  assign accept           = grant_vld && core_req_rdy_i;
  assign cancel_fwd       = last_vld_q && ch_cancel_i[last_ch_q];
  assign core_req_vld_o   = grant_vld;
  assign core_req_ch_o    = grant_id;
  assign ch_req_rdy_o     = grant & {NUM_CH{core_req_rdy_i}};
  assign core_cancel_o    = cancel_fwd;
  assign ch_ack_en_o      = ack_hit;
  assign ch_ack_dat_o     = core_ack_dat_i;
  assign ch_credit_full_o = full_q;
  assign err_underflow_o  = err_q;

  // Next state: pointers, last-accept tracking, credits floored at zero.
  always_comb begin
    cnt_d      = cnt_q;
    full_d     = '0;
    err_d      = err_q;
    last_ch_d  = last_ch_q;
    last_vld_d = accept;
    inc_v      = 1'b0;
    sum_v      = '0;
    dec_v      = '0;
`ifdef L1D_UPARB_QOS_EN
    rr_hi_d    = rr_hi_q;
    rr_lo_d    = rr_lo_q;
    if (accept) begin
      if (hi_sel) rr_hi_d = ptr_after(grant_id);
      else        rr_lo_d = ptr_after(grant_id);
    end
`else
    rr_d       = rr_q;
    if (accept) rr_d = ptr_after(grant_id);
`endif
    if (accept) last_ch_d = grant_id;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      inc_v = accept && (grant_id == CH_W'(i));
      dec_v = CNT_X'(ack_hit[i]) + CNT_X'(cancel_fwd && (last_ch_q == CH_W'(i)));
      sum_v = {1'b0, cnt_q[i]} + CNT_X'(inc_v);
      if (sum_v < dec_v) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = CNT_W'(sum_v - dec_v);
      end
      full_d[i] = (cnt_d[i] == CNT_W'(OST_MAX));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      full_q     <= '0;
      err_q      <= 1'b0;
      last_ch_q  <= '0;
      last_vld_q <= 1'b0;
`ifdef L1D_UPARB_QOS_EN
      rr_hi_q    <= '0;
      rr_lo_q    <= '0;
`else
      rr_q       <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      err_q      <= err_d;
      last_ch_q  <= last_ch_d;
      last_vld_q <= last_vld_d;
`ifdef L1D_UPARB_QOS_EN
      rr_hi_q    <= rr_hi_d;
      rr_lo_q    <= rr_lo_d;
`else
      rr_q       <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_l1d_upstream_arb.sv
// Testbench for l1d_upstream_arb: grant scoreboard plus directed checks of
// routing, credits, cancel and the sticky underflow flag.
module tb_l1d_upstream_arb;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PLD_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_req_vld, ch_req_rdy, ch_cancel;
  logic [NUM_CH*PLD_W-1:0] ch_req_pld;
  logic [NUM_CH-1:0]       ch_tag_hit, ch_ack_en, ch_credit_full;
  logic [DATA_W-1:0]       ch_ack_dat;
  logic                    core_req_vld, core_req_rdy, core_cancel;
  logic [PLD_W-1:0]        core_req_pld;
  logic [CH_W-1:0]         core_req_ch, core_ack_ch;
  logic                    core_tag_hit, core_ack_en, err_underflow;
  logic [DATA_W-1:0]       core_ack_dat;
`ifdef L1D_UPARB_QOS_EN
  logic [NUM_CH-1:0]       ch_prio;
`endif

  int total = 0;
  int bad   = 0;
  int unsigned exp_q[$];

  l1d_upstream_arb #(
    .NUM_CH(NUM_CH), .PLD_W(PLD_W), .DATA_W(DATA_W), .OST_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_vld_i(ch_req_vld), .ch_req_rdy_o(ch_req_rdy),
    .ch_req_pld_i(ch_req_pld), .ch_cancel_i(ch_cancel),
`ifdef L1D_UPARB_QOS_EN
    .ch_prio_i(ch_prio),
`endif
    .ch_tag_hit_o(ch_tag_hit), .ch_ack_en_o(ch_ack_en),
    .ch_ack_dat_o(ch_ack_dat), .ch_credit_full_o(ch_credit_full),
    .core_req_vld_o(core_req_vld), .core_req_rdy_i(core_req_rdy),
    .core_req_pld_o(core_req_pld), .core_req_ch_o(core_req_ch),
    .core_cancel_o(core_cancel), .core_tag_hit_i(core_tag_hit),
    .core_ack_en_i(core_ack_en), .core_ack_ch_i(core_ack_ch),
    .core_ack_dat_i(core_ack_dat), .err_underflow_o(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant monitor: every accepted request must match the next expected channel.
  always @(negedge clk) begin
    int unsigned e;
    if (rst_n === 1'b1 && core_req_vld === 1'b1 && core_req_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant actual=%0d required=none", core_req_ch);
      end else begin
        e = exp_q.pop_front();
        chk("grant_ch", 64'(core_req_ch), 64'(e));
        chk("grant_pld", 64'(core_req_pld), 64'(16'hC0D0 + 16'(e)));
      end
    end
  end

  task automatic ack(input int unsigned ch);
    core_ack_en  = 1'b1;
    core_ack_ch  = CH_W'(ch);
    core_ack_dat = 32'hDA7A_0000 + ch;
    @(negedge clk);
    chk("ack_en", 64'(ch_ack_en), 64'(4'b0001 << ch));
    chk("ack_dat", 64'(ch_ack_dat), 64'(32'hDA7A_0000 + ch));
    tick();
    core_ack_en = 1'b0;
  endtask

  task automatic push_n(input int unsigned ch, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(ch);
  endtask

  initial begin
    rst_n = 1'b0;
    ch_req_vld = '0; ch_cancel = '0; core_req_rdy = 1'b0;
    core_tag_hit = 1'b0; core_ack_en = 1'b0; core_ack_ch = '0; core_ack_dat = '0;
`ifdef L1D_UPARB_QOS_EN
    ch_prio = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) ch_req_pld[i*PLD_W +: PLD_W] = 16'hC0D0 + 16'(i);
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    chk("rst_req_vld", 64'(core_req_vld), 0);
    chk("rst_req_pld", 64'(core_req_pld), 0);
    chk("rst_credit_full", 64'(ch_credit_full), 0);
    chk("rst_err", 64'(err_underflow), 0);
    chk("rst_tag_hit", 64'(ch_tag_hit), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // All channels valid: grants 0,1,2,3,0
    ch_req_vld = 4'b1111; core_req_rdy = 1'b1;
    push_n(0, 1); push_n(1, 1); push_n(2, 1); push_n(3, 1); push_n(0, 1);
    repeat (5) tick();
    ch_req_vld = '0;
    @(negedge clk);
    chk("idle_req_vld", 64'(core_req_vld), 0);
    tick();
    ack(0); ack(0); ack(1); ack(2); ack(3);
    @(negedge clk);
    chk("rr_err", 64'(err_underflow), 0);
    tick();

    // Credit limit on ch2
    ch_req_vld = 4'b0100;
    push_n(2, 4);
    repeat (4) tick();
    @(negedge clk);
    chk("full_req_vld", 64'(core_req_vld), 0);
    chk("full_ch2", 64'(ch_credit_full), 64'(4'b0100));
    chk("full_rdy", 64'(ch_req_rdy), 0);
    tick();
    core_ack_en = 1'b1; core_ack_ch = 2'd2;
    push_n(2, 1);
    @(negedge clk);
    chk("full_ack_cycle_vld", 64'(core_req_vld), 0);
    tick();
    core_ack_en = 1'b0;
    @(negedge clk);
    chk("refill_req_vld", 64'(core_req_vld), 1);
    chk("refill_rdy", 64'(ch_req_rdy), 64'(4'b0100));
    tick();
    ch_req_vld = '0;
    @(negedge clk);
    chk("refull_ch2", 64'(ch_credit_full), 64'(4'b0100));
    tick();
    repeat (4) ack(2);
    @(negedge clk);
    chk("drain_ch2_full", 64'(ch_credit_full), 0);
    tick();

    // Tag hit routing and cancel filtering on ch1
    ch_req_vld = 4'b0010;
    push_n(1, 1);
    tick();
    ch_req_vld = '0; core_tag_hit = 1'b1; ch_cancel = 4'b0001;
    @(negedge clk);
    chk("tag_hit_ch1", 64'(ch_tag_hit), 64'(4'b0010));
    chk("cancel_other_ch", 64'(core_cancel), 0);
    tick();
    @(negedge clk);
    chk("tag_hit_no_last", 64'(ch_tag_hit), 0);
    tick();
    core_tag_hit = 1'b0; ch_cancel = '0;
    ack(1);
    ch_req_vld = 4'b0010;
    push_n(1, 1);
    tick();
    ch_req_vld = '0; ch_cancel = 4'b0010; core_tag_hit = 1'b1;
    @(negedge clk);
    chk("cancel_fwd", 64'(core_cancel), 1);
    chk("tag_hit_ch1_b", 64'(ch_tag_hit), 64'(4'b0010));
    tick();
    @(negedge clk);
    chk("cancel_no_last", 64'(core_cancel), 0);
    tick();
    ch_cancel = '0; core_tag_hit = 1'b0;
    // ch1 must be back at 0: exactly 4 accepts reach the limit
    ch_req_vld = 4'b0010;
    push_n(1, 4);
    repeat (4) tick();
    @(negedge clk);
    chk("cancel_refill_vld", 64'(core_req_vld), 0);
    chk("cancel_refill_full", 64'(ch_credit_full), 64'(4'b0010));
    chk("cancel_err", 64'(err_underflow), 0);
    tick();
    ch_req_vld = '0;
    repeat (4) ack(1);

    // Simultaneous accept and ack on ch3 at cnt=2
    ch_req_vld = 4'b1000;
    push_n(3, 5);
    tick(); tick();
    core_ack_en = 1'b1; core_ack_ch = 2'd3;
    @(negedge clk);
    chk("simul_ack_en", 64'(ch_ack_en), 64'(4'b1000));
    tick();
    core_ack_en = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("simul_req_vld", 64'(core_req_vld), 0);
    chk("simul_full", 64'(ch_credit_full), 64'(4'b1000));
    tick();
    ch_req_vld = '0;
    repeat (4) ack(3);

    // Underflow on ch0
    core_ack_en = 1'b1; core_ack_ch = 2'd0;
    @(negedge clk);
    chk("uf_ack_en", 64'(ch_ack_en), 64'(4'b0001));
    chk("uf_err_before", 64'(err_underflow), 0);
    tick();
    core_ack_en = 1'b0;
    @(negedge clk);
    chk("uf_err_set", 64'(err_underflow), 1);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("uf_err_sticky", 64'(err_underflow), 1);
    tick();
    rst_n = 1'b0; core_req_rdy = 1'b0;
    #1;
    chk("uf_err_reset", 64'(err_underflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Backpressure: request held with no ready
    ch_req_vld = 4'b0011;
    @(negedge clk);
    chk("bp_req_vld", 64'(core_req_vld), 1);
    chk("bp_req_ch", 64'(core_req_ch), 0);
    chk("bp_req_pld", 64'(core_req_pld), 64'(16'hC0D0));
    chk("bp_rdy", 64'(ch_req_rdy), 0);
    tick();
    core_req_rdy = 1'b1;
    push_n(0, 1); push_n(1, 1);
    tick(); tick();
    ch_req_vld = '0;
    ack(0); ack(1);

`ifdef L1D_UPARB_QOS_EN
    // Priority class wins, then RR resumes in the low class
    ch_req_vld = 4'b0011; ch_prio = 4'b0010;
    push_n(1, 3);
    repeat (3) tick();
    ch_prio = '0;
    push_n(0, 1); push_n(1, 1);
    repeat (2) tick();
    ch_req_vld = '0;
    repeat (4) ack(1);
    ack(0);
`endif

    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 0);
    chk("final_err", 64'(err_underflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
